axi_txn_tracker: RTL and testbench
==================================

Name: axi_txn_tracker

Overview:
- Parametrised, fully registered successor to the combinational write-transaction manager in the AXI monitor.
- Tracks up to MaxTxns outstanding AXI transactions for one channel direction (write: AW→B, read: AR→last R).
- Each transaction gets a prescaled timeout budget. Per-ID ordering is preserved, and the block reports completions with latency, timeouts and unexpected responses.
- Sits between the bus-snooping front end and the monitor register file / IRQ logic. The monitor instantiates one tracker per direction.

Parameters:
- MaxTxns, 8, number of tracking entries (≥2).
- IdWidth, 4, AXI ID width.
- CntWidth, 10, budget/latency counter width.
- PrescalerDiv, 4, clock cycles per budget tick (power of two, ≥1).
- IsRead, 0, 0 = write mode (every response completes); 1 = read mode (only rsp_last_i completes).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all entries
- base_budget_i  in  CntWidth  fixed budget component, in ticks
- req_valid_i  in  1  request handshake observed on bus
- req_ready_o  out  1  free entry available
- req_id_i  in  IdWidth  request ID
- req_len_i  in  8  AXI len
- rsp_valid_i  in  1  response handshake observed
- rsp_id_i  in  IdWidth  response ID
- rsp_last_i  in  1  last beat (ignored when IsRead=0)
- done_o  out  1  completion pulse
- done_id_o  out  IdWidth  completed ID
- latency_o  out  CntWidth  elapsed ticks of completed txn
- timeout_o  out  1  timeout pulse
- timeout_id_o  out  IdWidth  timed-out ID
- unexpected_o  out  1  response with no matching entry
- unexpected_id_o  out  IdWidth  its ID
- outstanding_o  out  $clog2(MaxTxns+1)  number of valid entries

Behaviour:
- Reset/flush: all entries invalid, prescaler = 0, all pulse outputs 0, ID/latency outputs 0, outstanding_o = 0, req_ready_o = 1. Flush takes priority over every other event in that cycle.
- Entry state: valid, id, budget (initial), remain (down-counter), and an age row older[MaxTxns].
- Allocation:
  - Occurs when req_valid_i && req_ready_o.
  - req_ready_o = any entry invalid in registered state. An entry freed this cycle is not reusable until the next cycle.
  - The lowest-index free entry is chosen.
  - budget = base_budget_i + ((req_len_i+1) >> log2(PrescalerDiv)) + 1, saturating at 2^CntWidth−1. remain = budget.
  - older[k][j] = 1 for every valid j with the same ID that is not completing this cycle.
- Tick: a prescaler counter wraps every PrescalerDiv cycles. On a wrap, every valid entry with remain > 0 decrements. An entry allocated in the same cycle does not decrement.
- Response match:
  - Target = the valid entry with id == rsp_id_i and no valid older bit set (oldest of that ID).
  - None found → unexpected_o = 1 and unexpected_id_o = rsp_id_i next cycle; no state change.
  - Found, and (IsRead=0 or rsp_last_i) → entry freed. done_o = 1, done_id_o = id, latency_o = budget − remain, all next cycle. Column target is cleared in every older row.
  - Found, read mode, not last → no change.
- Timeout:
  - Lowest-index valid entry with remain == 0 and not completing this cycle is freed. timeout_o = 1 and timeout_id_o set next cycle. Its older column is cleared.
  - Further zero-remain entries are reported one per cycle on following cycles.
- Priority: completion beats timeout on the same entry (no timeout reported).
- Concurrency: allocation, completion and timeout may all occur in one cycle, on distinct entries.
- Latency: all outputs are registered, 1-cycle latency from the triggering event.
- Pulses: all *_o pulses last one cycle. The ID/latency outputs hold their values until the next event of their kind.
- outstanding_o: registered popcount of valid entries.

Test Plan:
- Write mode, PrescalerDiv=4, base_budget_i=10: AW id 3 len 3, B id 3 after 20 cycles → done_o, done_id_o=3, latency_o=5 (budget 12, remain 7).
- Same-ID ordering: AW id 1 len 0 then AW id 1 len 15 (budgets 11, 15); B id 1 → latency tied to first entry; outstanding_o goes 2→1.
- Timeout: base_budget_i=2, len 0, no response → timeout_o at cycle (budget 3 ticks × 4)+1, timeout_id_o=id, entry freed, outstanding_o=0. Two entries with equal budget time out on consecutive cycles, lower index first.
- Unexpected: B id 5 with no id 5 outstanding → unexpected_o=1, unexpected_id_o=5, outstanding_o unchanged.
- Full/simultaneous: fill 8 entries → req_ready_o=0; a B completion in a cycle keeps req_ready_o=0 that cycle and sets it to 1 the next; allocation plus completion of the same ID in one cycle → the new entry becomes oldest afterward.
- IsRead=1: R beats with last=0 for id 2 → no done_o; last=1 → done_o. Assert rst_ni low mid-burst → all outputs 0 asynchronously and outstanding_o=0.

Source files
------------

// File: rtl/axi_txn_tracker.sv
// Tracks outstanding AXI transactions for one direction: keeps per-ID order, applies prescaled timeouts, reports latency.
// All outputs are registered with 1-cycle latency. req_ready_o drops while every entry is in use, and a freed entry is reusable the cycle after.
module axi_txn_tracker #(
    parameter int MaxTxns      = 8,
    parameter int IdWidth      = 4,
    parameter int CntWidth     = 10,
    parameter int PrescalerDiv = 4,
    parameter int IsRead       = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [CntWidth-1:0]           base_budget_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IdWidth-1:0]            req_id_i,
    input  logic [7:0]                    req_len_i,
    input  logic                          rsp_valid_i,
    input  logic [IdWidth-1:0]            rsp_id_i,
    input  logic                          rsp_last_i,
    output logic                          done_o,
    output logic [IdWidth-1:0]            done_id_o,
    output logic [CntWidth-1:0]           latency_o,
    output logic                          timeout_o,
    output logic [IdWidth-1:0]            timeout_id_o,
    output logic                          unexpected_o,
    output logic [IdWidth-1:0]            unexpected_id_o,
    output logic [$clog2(MaxTxns+1)-1:0]  outstanding_o
);

    localparam int IdxW    = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
    localparam int OutW    = $clog2(MaxTxns + 1);
    localparam int PsW     = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int PsShift = $clog2(PrescalerDiv);
    localparam int SumW    = CntWidth + 10;
    localparam logic [MaxTxns-1:0] OneHot0 = MaxTxns'(1);

    logic [MaxTxns-1:0]  r_valid;
    logic [IdWidth-1:0]  r_id     [MaxTxns];
    logic [CntWidth-1:0] r_budget [MaxTxns];
    logic [CntWidth-1:0] r_remain [MaxTxns];
    // r_older[k][j] set: entry j carries the same ID and was issued before k
    logic [MaxTxns-1:0]  r_older  [MaxTxns];
    logic [PsW-1:0]      r_presc;

    logic                r_done;
    logic [IdWidth-1:0]  r_done_id;
    logic [CntWidth-1:0] r_latency;
    logic                r_timeout;
    logic [IdWidth-1:0]  r_timeout_id;
    logic                r_unexp;
    logic [IdWidth-1:0]  r_unexp_id;
    logic [OutW-1:0]     r_outstanding;

    logic                w_tick;
    logic                w_alloc_found;
    logic [IdxW-1:0]     w_alloc_idx;
    logic                w_alloc;
    logic                w_match_found;
    logic [IdxW-1:0]     w_match_idx;
    logic                w_cmpl;
    logic                w_unexp;
    logic                w_to_found;
    logic [IdxW-1:0]     w_to_idx;
    logic [SumW-1:0]     w_len_term;
    logic [SumW-1:0]     w_sum;
    logic [CntWidth-1:0] w_budget;
    logic [MaxTxns-1:0]  w_free_mask;
    logic [MaxTxns-1:0]  w_valid_nxt;
    logic [MaxTxns-1:0]  w_older_nxt [MaxTxns];
    logic [OutW-1:0]     w_count;

    assign w_tick = (r_presc == PsW'(PrescalerDiv - 1));

    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int k = 0; k < MaxTxns; k++) begin
            if (!r_valid[k] && !w_alloc_found) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = IdxW'(k);
            end
        end
    end

    assign req_ready_o = w_alloc_found;
    assign w_alloc     = req_valid_i && w_alloc_found;

    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        for (int k = 0; k < MaxTxns; k++) begin
            if (r_valid[k] && (r_id[k] == rsp_id_i) && ((r_older[k] & r_valid) == '0)
                && !w_match_found) begin
                w_match_found = 1'b1;
                w_match_idx   = IdxW'(k);
            end
        end
    end

    assign w_cmpl  = rsp_valid_i && w_match_found && ((IsRead == 0) || rsp_last_i);
    assign w_unexp = rsp_valid_i && !w_match_found;

    // A completing entry is never reported as timed out in the same cycle
    always_comb begin
        w_to_found = 1'b0;
        w_to_idx   = '0;
        for (int k = 0; k < MaxTxns; k++) begin
            if (r_valid[k] && (r_remain[k] == '0) && !(w_cmpl && (w_match_idx == IdxW'(k)))
                && !w_to_found) begin
                w_to_found = 1'b1;
                w_to_idx   = IdxW'(k);
            end
        end
    end

    always_comb begin
        w_len_term = (SumW'(req_len_i) + SumW'(1)) >> PsShift;
        w_sum      = SumW'(base_budget_i) + w_len_term + SumW'(1);
        w_budget   = (w_sum[SumW-1:CntWidth] != '0) ? '1 : w_sum[CntWidth-1:0];
    end

    always_comb begin
        w_free_mask = '0;
        if (w_cmpl) begin
            w_free_mask = w_free_mask | (OneHot0 << w_match_idx);
        end
        if (w_to_found) begin
            w_free_mask = w_free_mask | (OneHot0 << w_to_idx);
        end
        w_valid_nxt = r_valid & ~w_free_mask;
        if (w_alloc) begin
            w_valid_nxt = w_valid_nxt | (OneHot0 << w_alloc_idx);
        end
    end

    // Freed columns are cleared after the new row is built so no stale dependency survives
    always_comb begin
        for (int k = 0; k < MaxTxns; k++) begin
            w_older_nxt[k] = r_older[k];
            if (w_alloc && (IdxW'(k) == w_alloc_idx)) begin
                for (int j = 0; j < MaxTxns; j++) begin
                    w_older_nxt[k][j] = r_valid[j] && (r_id[j] == req_id_i);
                end
            end
            w_older_nxt[k] = w_older_nxt[k] & ~w_free_mask;
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < MaxTxns; k++) begin
            w_count = w_count + OutW'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= '0;
            r_presc       <= '0;
            r_done        <= 1'b0;
            r_done_id     <= '0;
            r_latency     <= '0;
            r_timeout     <= 1'b0;
            r_timeout_id  <= '0;
            r_unexp       <= 1'b0;
            r_unexp_id    <= '0;
            r_outstanding <= '0;
            for (int k = 0; k < MaxTxns; k++) begin
                r_id[k]     <= '0;
                r_budget[k] <= '0;
                r_remain[k] <= '0;
                r_older[k]  <= '0;
            end
        end else if (flush_i) begin
            r_valid       <= '0;
            r_presc       <= '0;
            r_done        <= 1'b0;
            r_done_id     <= '0;
            r_latency     <= '0;
            r_timeout     <= 1'b0;
            r_timeout_id  <= '0;
            r_unexp       <= 1'b0;
            r_unexp_id    <= '0;
            r_outstanding <= '0;
            for (int k = 0; k < MaxTxns; k++) begin
                r_older[k] <= '0;
            end
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PsW'(1);
            for (int k = 0; k < MaxTxns; k++) begin
                r_older[k] <= w_older_nxt[k];
                if (w_tick && r_valid[k] && (r_remain[k] != '0)) begin
                    r_remain[k] <= r_remain[k] - CntWidth'(1);
                end
            end
            if (w_alloc) begin
                r_id[w_alloc_idx]     <= req_id_i;
                r_budget[w_alloc_idx] <= w_budget;
                r_remain[w_alloc_idx] <= w_budget;
            end
            r_valid       <= w_valid_nxt;
            r_outstanding <= w_count;

            r_done <= w_cmpl;
            if (w_cmpl) begin
                r_done_id <= r_id[w_match_idx];
                r_latency <= r_budget[w_match_idx] - r_remain[w_match_idx];
            end
            r_timeout <= w_to_found;
            if (w_to_found) begin
                r_timeout_id <= r_id[w_to_idx];
            end
            r_unexp <= w_unexp;
            if (w_unexp) begin
                r_unexp_id <= rsp_id_i;
            end
        end
    end

    assign done_o          = r_done;
    assign done_id_o       = r_done_id;
    assign latency_o       = r_latency;
    assign timeout_o       = r_timeout;
    assign timeout_id_o    = r_timeout_id;
    assign unexpected_o    = r_unexp;
    assign unexpected_id_o = r_unexp_id;
    assign outstanding_o   = r_outstanding;

endmodule

// File: tb/tb_axi_txn_tracker.sv
// Directed bench for axi_txn_tracker: a write-mode instance and a read-mode instance.
module tb_axi_txn_tracker;

    logic       clk;
    logic       rst_n;
    logic       rst_rd_n;
    logic       flush;
    logic [9:0] base;
    logic       req_valid_wr, req_valid_rd;
    logic [3:0] req_id;
    logic [7:0] req_len;
    logic       rsp_valid_wr, rsp_valid_rd;
    logic [3:0] rsp_id;
    logic       rsp_last;

    logic       ready_wr, done_wr, to_wr, unx_wr;
    logic [3:0] done_id_wr, to_id_wr, unx_id_wr, out_wr;
    logic [9:0] lat_wr;
    logic       ready_rd, done_rd, to_rd, unx_rd;
    logic [3:0] done_id_rd, to_id_rd, unx_id_rd, out_rd;
    logic [9:0] lat_rd;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_txn_tracker #(.MaxTxns(8), .IdWidth(4), .CntWidth(10), .PrescalerDiv(4), .IsRead(0)) u_wr (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .base_budget_i(base),
        .req_valid_i(req_valid_wr), .req_ready_o(ready_wr), .req_id_i(req_id), .req_len_i(req_len),
        .rsp_valid_i(rsp_valid_wr), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last),
        .done_o(done_wr), .done_id_o(done_id_wr), .latency_o(lat_wr),
        .timeout_o(to_wr), .timeout_id_o(to_id_wr),
        .unexpected_o(unx_wr), .unexpected_id_o(unx_id_wr), .outstanding_o(out_wr)
    );

    axi_txn_tracker #(.MaxTxns(8), .IdWidth(4), .CntWidth(10), .PrescalerDiv(4), .IsRead(1)) u_rd (
        .clk_i(clk), .rst_ni(rst_rd_n), .flush_i(flush), .base_budget_i(base),
        .req_valid_i(req_valid_rd), .req_ready_o(ready_rd), .req_id_i(req_id), .req_len_i(req_len),
        .rsp_valid_i(rsp_valid_rd), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last),
        .done_o(done_rd), .done_id_o(done_id_rd), .latency_o(lat_rd),
        .timeout_o(to_rd), .timeout_id_o(to_id_rd),
        .unexpected_o(unx_rd), .unexpected_id_o(unx_id_rd), .outstanding_o(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flushing aligns the prescaler: the next edge is a non-tick edge, ticks follow every 4th edge
    task automatic sync();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (ready_wr !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %0d want 1", ready_wr); end
        tests_run++; if (out_wr !== 4'd0) begin tests_failed++; $display("FAIL rst_outstanding: got %0d want 0", out_wr); end
        tests_run++; if ({done_wr, to_wr, unx_wr} !== 3'b000) begin tests_failed++; $display("FAIL rst_pulses: got %b want 000", {done_wr, to_wr, unx_wr}); end
        tests_run++; if ({done_id_wr, to_id_wr, unx_id_wr, lat_wr} !== 22'd0) begin tests_failed++; $display("FAIL rst_ids: got %h want 0", {done_id_wr, to_id_wr, unx_id_wr, lat_wr}); end
    endtask

    task automatic test_latency();
        base = 10'd10;
        sync();
        req_id = 4'd3; req_len = 8'd3; req_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0;
        tests_run++; if (out_wr !== 4'd1) begin tests_failed++; $display("FAIL lat_out1: got %0d want 1", out_wr); end
        repeat (19) step();
        rsp_id = 4'd3; rsp_valid_wr = 1'b1;
        step();
        rsp_valid_wr = 1'b0;
        tests_run++; if (done_wr !== 1'b1) begin tests_failed++; $display("FAIL lat_done: got %0d want 1", done_wr); end
        tests_run++; if (done_id_wr !== 4'd3) begin tests_failed++; $display("FAIL lat_id: got %0d want 3", done_id_wr); end
        tests_run++; if (lat_wr !== 10'd5) begin tests_failed++; $display("FAIL lat_value: got %0d want 5", lat_wr); end
        tests_run++; if (out_wr !== 4'd0) begin tests_failed++; $display("FAIL lat_out0: got %0d want 0", out_wr); end
        step();
        tests_run++; if (done_wr !== 1'b0) begin tests_failed++; $display("FAIL lat_pulse: got %0d want 0", done_wr); end
        tests_run++; if (done_id_wr !== 4'd3) begin tests_failed++; $display("FAIL lat_hold: got %0d want 3", done_id_wr); end
    endtask

    task automatic test_same_id();
        base = 10'd10;
        sync();
        req_len = 8'd0;
        req_id = 4'd9; req_valid_wr = 1'b1;
        step();
        req_id = 4'd1;
        step();
        req_valid_wr = 1'b0;
        step();
        rsp_id = 4'd9; rsp_valid_wr = 1'b1;
        step();
        rsp_valid_wr = 1'b0;
        tests_run++; if (done_id_wr !== 4'd9 || lat_wr !== 10'd0) begin tests_failed++; $display("FAIL ord_free0: got id %0d lat %0d want id 9 lat 0", done_id_wr, lat_wr); end
        req_id = 4'd1; req_len = 8'd15; req_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0;
        tests_run++; if (out_wr !== 4'd2) begin tests_failed++; $display("FAIL ord_out2: got %0d want 2", out_wr); end
        repeat (3) step();
        rsp_id = 4'd1; rsp_valid_wr = 1'b1;
        step();
        tests_run++; if (done_wr !== 1'b1 || done_id_wr !== 4'd1) begin tests_failed++; $display("FAIL ord_done1: got done %0d id %0d want 1/1", done_wr, done_id_wr); end
        tests_run++; if (lat_wr !== 10'd2) begin tests_failed++; $display("FAIL ord_lat_first: got %0d want 2", lat_wr); end
        tests_run++; if (out_wr !== 4'd1) begin tests_failed++; $display("FAIL ord_out1: got %0d want 1", out_wr); end
        step();
        rsp_valid_wr = 1'b0;
        tests_run++; if (done_wr !== 1'b1 || lat_wr !== 10'd1) begin tests_failed++; $display("FAIL ord_lat_second: got done %0d lat %0d want 1/1", done_wr, lat_wr); end
        tests_run++; if (out_wr !== 4'd0) begin tests_failed++; $display("FAIL ord_out0: got %0d want 0", out_wr); end
    endtask

    task automatic test_timeout();
        base = 10'd2; req_len = 8'd0;
        sync();
        req_id = 4'd4; req_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0;
        repeat (11) step();
        tests_run++; if (to_wr !== 1'b0 || out_wr !== 4'd1) begin tests_failed++; $display("FAIL to_early: got to %0d out %0d want 0/1", to_wr, out_wr); end
        step();
        tests_run++; if (to_wr !== 1'b1 || to_id_wr !== 4'd4) begin tests_failed++; $display("FAIL to_fire: got to %0d id %0d want 1/4", to_wr, to_id_wr); end
        tests_run++; if (out_wr !== 4'd0) begin tests_failed++; $display("FAIL to_out: got %0d want 0", out_wr); end
        step();
        tests_run++; if (to_wr !== 1'b0 || to_id_wr !== 4'd4) begin tests_failed++; $display("FAIL to_pulse: got to %0d id %0d want 0/4", to_wr, to_id_wr); end

        sync();
        req_id = 4'd6; req_valid_wr = 1'b1;
        step();
        req_id = 4'd7;
        step();
        req_valid_wr = 1'b0;
        repeat (10) step();
        step();
        tests_run++; if (to_wr !== 1'b1 || to_id_wr !== 4'd6 || out_wr !== 4'd1) begin tests_failed++; $display("FAIL to_two_first: got to %0d id %0d out %0d want 1/6/1", to_wr, to_id_wr, out_wr); end
        step();
        tests_run++; if (to_wr !== 1'b1 || to_id_wr !== 4'd7 || out_wr !== 4'd0) begin tests_failed++; $display("FAIL to_two_second: got to %0d id %0d out %0d want 1/7/0", to_wr, to_id_wr, out_wr); end
        step();
        tests_run++; if (to_wr !== 1'b0) begin tests_failed++; $display("FAIL to_two_end: got %0d want 0", to_wr); end
    endtask

    task automatic test_saturation();
        int n;
        base = 10'd1020; req_len = 8'd255;
        sync();
        req_id = 4'd12; req_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0;
        n = 0;
        while (to_wr !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        tests_run++; if (n != 4092) begin tests_failed++; $display("FAIL sat_cycles: got %0d want 4092", n); end
        tests_run++; if (to_id_wr !== 4'd12) begin tests_failed++; $display("FAIL sat_id: got %0d want 12", to_id_wr); end
    endtask

    task automatic test_unexpected();
        base = 10'd10; req_len = 8'd0;
        sync();
        req_id = 4'd3; req_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0;
        rsp_id = 4'd5; rsp_valid_wr = 1'b1;
        step();
        rsp_valid_wr = 1'b0;
        tests_run++; if (unx_wr !== 1'b1 || unx_id_wr !== 4'd5) begin tests_failed++; $display("FAIL unx_fire: got %0d id %0d want 1/5", unx_wr, unx_id_wr); end
        tests_run++; if (out_wr !== 4'd1 || done_wr !== 1'b0) begin tests_failed++; $display("FAIL unx_state: got out %0d done %0d want 1/0", out_wr, done_wr); end
        step();
        tests_run++; if (unx_wr !== 1'b0 || unx_id_wr !== 4'd5) begin tests_failed++; $display("FAIL unx_pulse: got %0d id %0d want 0/5", unx_wr, unx_id_wr); end
    endtask

    task automatic test_full();
        base = 10'd500; req_len = 8'd0;
        sync();
        req_valid_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_id = 4'(i);
            step();
            if (i == 6) begin
                tests_run++; if (ready_wr !== 1'b1) begin tests_failed++; $display("FAIL full_ready7: got %0d want 1", ready_wr); end
            end
        end
        req_valid_wr = 1'b0;
        tests_run++; if (ready_wr !== 1'b0 || out_wr !== 4'd8) begin tests_failed++; $display("FAIL full_ready8: got ready %0d out %0d want 0/8", ready_wr, out_wr); end
        rsp_id = 4'd2; rsp_valid_wr = 1'b1;
        req_id = 4'd13; req_valid_wr = 1'b1;
        #1;
        tests_run++; if (ready_wr !== 1'b0) begin tests_failed++; $display("FAIL full_same_cycle: got %0d want 0", ready_wr); end
        step();
        tests_run++; if (ready_wr !== 1'b1 || out_wr !== 4'd7) begin tests_failed++; $display("FAIL full_next: got ready %0d out %0d want 1/7", ready_wr, out_wr); end
        tests_run++; if (done_wr !== 1'b1 || done_id_wr !== 4'd2) begin tests_failed++; $display("FAIL full_done: got %0d id %0d want 1/2", done_wr, done_id_wr); end
        req_id = 4'd3; rsp_id = 4'd3;
        step();
        req_valid_wr = 1'b0;
        tests_run++; if (out_wr !== 4'd7 || done_id_wr !== 4'd3) begin tests_failed++; $display("FAIL swap_state: got out %0d id %0d want 7/3", out_wr, done_id_wr); end
        step();
        rsp_valid_wr = 1'b0;
        tests_run++; if (done_wr !== 1'b1 || unx_wr !== 1'b0 || out_wr !== 4'd6) begin tests_failed++; $display("FAIL swap_new_oldest: got done %0d unx %0d out %0d want 1/0/6", done_wr, unx_wr, out_wr); end
    endtask

    task automatic test_concurrent();
        base = 10'd2; req_len = 8'd0;
        sync();
        req_id = 4'd8; req_valid_wr = 1'b1;
        step();
        req_id = 4'd9;
        step();
        req_valid_wr = 1'b0;
        repeat (10) step();
        req_id = 4'd11; req_valid_wr = 1'b1;
        rsp_id = 4'd8; rsp_valid_wr = 1'b1;
        step();
        req_valid_wr = 1'b0; rsp_valid_wr = 1'b0;
        tests_run++; if (done_wr !== 1'b1 || done_id_wr !== 4'd8 || lat_wr !== 10'd3) begin tests_failed++; $display("FAIL conc_done: got %0d id %0d lat %0d want 1/8/3", done_wr, done_id_wr, lat_wr); end
        tests_run++; if (to_wr !== 1'b1 || to_id_wr !== 4'd9) begin tests_failed++; $display("FAIL conc_timeout: got %0d id %0d want 1/9", to_wr, to_id_wr); end
        tests_run++; if (out_wr !== 4'd1) begin tests_failed++; $display("FAIL conc_out: got %0d want 1", out_wr); end
        step();
        tests_run++; if (to_wr !== 1'b0 || done_wr !== 1'b0 || out_wr !== 4'd1) begin tests_failed++; $display("FAIL conc_after: got to %0d done %0d out %0d want 0/0/1", to_wr, done_wr, out_wr); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        req_id = 4'd5; req_valid_wr = 1'b1;
        rsp_id = 4'd11; rsp_valid_wr = 1'b1;
        step();
        flush = 1'b0; req_valid_wr = 1'b0; rsp_valid_wr = 1'b0;
        tests_run++; if (out_wr !== 4'd0 || ready_wr !== 1'b1) begin tests_failed++; $display("FAIL flush_state: got out %0d ready %0d want 0/1", out_wr, ready_wr); end
        tests_run++; if ({done_wr, to_wr, unx_wr} !== 3'b000) begin tests_failed++; $display("FAIL flush_pulses: got %b want 000", {done_wr, to_wr, unx_wr}); end
        tests_run++; if ({done_id_wr, to_id_wr, lat_wr} !== 18'd0) begin tests_failed++; $display("FAIL flush_ids: got %h want 0", {done_id_wr, to_id_wr, lat_wr}); end
    endtask

    task automatic test_read();
        base = 10'd10; req_len = 8'd3;
        req_id = 4'd2; req_valid_rd = 1'b1;
        step();
        req_valid_rd = 1'b0;
        tests_run++; if (out_rd !== 4'd1) begin tests_failed++; $display("FAIL rd_out1: got %0d want 1", out_rd); end
        rsp_id = 4'd2; rsp_last = 1'b0; rsp_valid_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (done_rd !== 1'b0 || unx_rd !== 1'b0) begin tests_failed++; $display("FAIL rd_beat%0d: got done %0d unx %0d want 0/0", i, done_rd, unx_rd); end
        end
        rsp_last = 1'b1;
        step();
        rsp_valid_rd = 1'b0; rsp_last = 1'b0;
        tests_run++; if (done_rd !== 1'b1 || done_id_rd !== 4'd2 || out_rd !== 4'd0) begin tests_failed++; $display("FAIL rd_last: got done %0d id %0d out %0d want 1/2/0", done_rd, done_id_rd, out_rd); end
        req_valid_rd = 1'b1;
        step();
        req_valid_rd = 1'b0;
        rsp_valid_rd = 1'b1;
        step();
        rsp_valid_rd = 1'b0;
        tests_run++; if (out_rd !== 4'd1) begin tests_failed++; $display("FAIL rd_mid_burst: got %0d want 1", out_rd); end
        #2;
        rst_rd_n = 1'b0;
        #1;
        tests_run++; if (out_rd !== 4'd0 || ready_rd !== 1'b1) begin tests_failed++; $display("FAIL rd_arst_state: got out %0d ready %0d want 0/1", out_rd, ready_rd); end
        tests_run++; if ({done_rd, to_rd, unx_rd, done_id_rd, to_id_rd, unx_id_rd, lat_rd} !== 25'd0) begin tests_failed++; $display("FAIL rd_arst_outputs: got %h want 0", {done_rd, to_rd, unx_rd, done_id_rd, to_id_rd, unx_id_rd, lat_rd}); end
        @(negedge clk);
        rst_rd_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; rst_rd_n = 1'b0; flush = 1'b0;
        base = '0; req_id = '0; req_len = '0; rsp_id = '0; rsp_last = 1'b0;
        req_valid_wr = 1'b0; req_valid_rd = 1'b0; rsp_valid_wr = 1'b0; rsp_valid_rd = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1; rst_rd_n = 1'b1;
        step();
        test_latency();
        test_same_id();
        test_timeout();
        test_saturation();
        test_unexpected();
        test_full();
        test_concurrent();
        test_flush();
        test_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
